// File: rtl/logicnet_input_quantizer_pkg.sv
// Shared definitions for the LogicNet input quantizer: default widths,
// threshold count, FSM state encoding and a reference quantization function.
package logicnet_pkg;

    localparam int BW_DEFAULT     = 2;
    localparam int FEAT_W_DEFAULT = 16;
    localparam int NUM_THR        = (2 ** BW_DEFAULT) - 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        FULL    = 2'd2
    } inq_state_t;

    // Thermometer-style code: how many thresholds the value reaches or exceeds.
    // Threshold order does not matter; each comparison is counted on its own.
    function automatic logic [BW_DEFAULT-1:0] quant_code(
        input logic [FEAT_W_DEFAULT-1:0]         value,
        input logic [NUM_THR*FEAT_W_DEFAULT-1:0] thr_vec
    );
        logic [BW_DEFAULT-1:0] cnt;
        cnt = {BW_DEFAULT{1'b0}};
        for (int k = 0; k < NUM_THR; k++) begin
            if (value >= thr_vec[k*FEAT_W_DEFAULT +: FEAT_W_DEFAULT]) begin
                cnt = cnt + {{(BW_DEFAULT-1){1'b0}}, 1'b1};
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/logicnet_thermo_quant.sv
// Combinational comparator bank plus popcount: turns one raw feature value
// and its row of thresholds into a BW-bit quantized code.
module logicnet_thermo_quant
    import logicnet_pkg::*;
#(
    parameter int FEAT_W = 16,
    parameter int BW     = 2
) (
    input  logic [FEAT_W-1:0]              value,
    input  logic [(2**BW-1)*FEAT_W-1:0]    thr_row,
    output logic [BW-1:0]                  code
);

    localparam int NTHR = (2 ** BW) - 1;

    generate
        if ((FEAT_W == FEAT_W_DEFAULT) && (BW == BW_DEFAULT)) begin : g_pkg
            assign code = quant_code(value, thr_row);
        end else begin : g_loop
            // Generic-width comparator bank and popcount
            always_comb begin
                code = {BW{1'b0}};
                for (int k = 0; k < NTHR; k++) begin
                    if (value >= thr_row[k*FEAT_W +: FEAT_W]) begin
                        code = code + BW'(1'b1);
                    end else begin
                        code = code;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/logicnet_input_quantizer.sv
// LogicNet input quantizer: accepts raw features one per beat, quantizes each
// against its programmable thresholds and packs the codes into one layer-0
// input vector presented on a valid/ready port.
// Optional build macro: LOGICNET_INQ_DOUBLE_BUFFER_EN adds a separate
// assembly register so the next vector can be collected while the previous
// one waits on the output.
module logicnet_input_quantizer
    import logicnet_pkg::*;
#(
    parameter int NUM_FEATURES = 32,
    parameter int FEAT_W       = 16,
    parameter int BW           = BW_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [FEAT_W-1:0]                 s_data,
    input  logic                              s_last,
    input  logic                              thr_we,
    input  logic [$clog2(NUM_FEATURES)-1:0]   thr_feat,
    input  logic [BW-1:0]                     thr_sel,
    input  logic [FEAT_W-1:0]                 thr_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [NUM_FEATURES*BW-1:0]        m_data,
    output logic                              err_frame
);

    localparam int                IDX_W    = $clog2(NUM_FEATURES);
    localparam int                NTHR     = (2 ** BW) - 1;
    localparam int                DATA_W   = NUM_FEATURES * BW;
    localparam int                ROW_W    = NTHR * FEAT_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    inq_state_t          state_r, state_next_s;
    logic [IDX_W-1:0]    idx_r, idx_next_s;
    logic [DATA_W-1:0]   data_r, data_next_s, merged_s;
    logic                m_valid_r, m_valid_next_s;
    logic                s_ready_r, s_ready_next_s;
    logic                err_frame_r, err_frame_next_s;
    logic                accept_s;
    logic [ROW_W-1:0]    thr_r [NUM_FEATURES];
    logic [ROW_W-1:0]    thr_row_s;
    logic [BW-1:0]       q_s;
`ifdef LOGICNET_INQ_DOUBLE_BUFFER_EN
    logic [DATA_W-1:0]   asm_r, asm_next_s;
    logic                out_free_s;
`endif

    assign accept_s  = s_valid & s_ready_r;
    assign thr_row_s = thr_r[idx_r];

    assign s_ready   = s_ready_r;
    assign m_valid   = m_valid_r;
    assign m_data    = data_r;
    assign err_frame = err_frame_r;

    logicnet_thermo_quant #(
        .FEAT_W (FEAT_W),
        .BW     (BW)
    ) u_quant (
        .value   (s_data),
        .thr_row (thr_row_s),
        .code    (q_s)
    );

    // Threshold table; the quantizer reads the registered value, so a write
    // only affects beats accepted on later cycles. Index NTHR is not a slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < NUM_FEATURES; f++) begin
                thr_r[f] <= {ROW_W{1'b0}};
            end
        end else if (thr_we && (thr_sel != {BW{1'b1}})) begin
            thr_r[thr_feat][thr_sel*FEAT_W +: FEAT_W] <= thr_data;
        end
    end

    // Splice the code of the current beat into the vector being assembled
    always_comb begin
`ifdef LOGICNET_INQ_DOUBLE_BUFFER_EN
        merged_s = asm_r;
`else
        merged_s = data_r;
`endif
        merged_s[idx_r*BW +: BW] = q_s;
    end

`ifdef LOGICNET_INQ_DOUBLE_BUFFER_EN
    assign out_free_s = ~m_valid_r | m_ready;

    // Next-state logic with separate assembly and output registers
    always_comb begin
        state_next_s     = state_r;
        idx_next_s       = idx_r;
        data_next_s      = data_r;
        asm_next_s       = asm_r;
        m_valid_next_s   = m_valid_r & ~m_ready;
        err_frame_next_s = 1'b0;
        case (state_r)
            COLLECT: begin
                if (accept_s) begin
                    if (idx_r == LAST_IDX) begin
                        idx_next_s       = {IDX_W{1'b0}};
                        err_frame_next_s = ~s_last;
                        if (out_free_s) begin
                            data_next_s    = merged_s;
                            m_valid_next_s = 1'b1;
                        end else begin
                            asm_next_s   = merged_s;
                            state_next_s = FULL;
                        end
                    end else if (s_last) begin
                        idx_next_s       = {IDX_W{1'b0}};
                        err_frame_next_s = 1'b1;
                    end else begin
                        asm_next_s = merged_s;
                        idx_next_s = idx_r + IDX_W'(1'b1);
                    end
                end else begin
                    state_next_s = COLLECT;
                end
            end
            FULL: begin
                if (out_free_s) begin
                    data_next_s    = asm_r;
                    m_valid_next_s = 1'b1;
                    state_next_s   = COLLECT;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: begin
                state_next_s = COLLECT;
            end
        endcase
        s_ready_next_s = (state_next_s == COLLECT);
    end
`else
    // Next-state logic with a single register that assembles and then holds
    always_comb begin
        state_next_s     = state_r;
        idx_next_s       = idx_r;
        data_next_s      = data_r;
        m_valid_next_s   = m_valid_r;
        err_frame_next_s = 1'b0;
        case (state_r)
            COLLECT: begin
                if (accept_s) begin
                    if (idx_r == LAST_IDX) begin
                        data_next_s      = merged_s;
                        idx_next_s       = {IDX_W{1'b0}};
                        m_valid_next_s   = 1'b1;
                        err_frame_next_s = ~s_last;
                        state_next_s     = HOLD;
                    end else if (s_last) begin
                        idx_next_s       = {IDX_W{1'b0}};
                        err_frame_next_s = 1'b1;
                    end else begin
                        data_next_s = merged_s;
                        idx_next_s  = idx_r + IDX_W'(1'b1);
                    end
                end else begin
                    state_next_s = COLLECT;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    m_valid_next_s = 1'b0;
                    idx_next_s     = {IDX_W{1'b0}};
                    state_next_s   = COLLECT;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = COLLECT;
            end
        endcase
        s_ready_next_s = (state_next_s == COLLECT);
    end
`endif

    // State, index and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= COLLECT;
            idx_r       <= {IDX_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
            m_valid_r   <= 1'b0;
            s_ready_r   <= 1'b0;
            err_frame_r <= 1'b0;
`ifdef LOGICNET_INQ_DOUBLE_BUFFER_EN
            asm_r       <= {DATA_W{1'b0}};
`endif
        end else begin
            state_r     <= state_next_s;
            idx_r       <= idx_next_s;
            data_r      <= data_next_s;
            m_valid_r   <= m_valid_next_s;
            s_ready_r   <= s_ready_next_s;
            err_frame_r <= err_frame_next_s;
`ifdef LOGICNET_INQ_DOUBLE_BUFFER_EN
            asm_r       <= asm_next_s;
`endif
        end
    end

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Self-checking bench for logicnet_input_quantizer. Expected vectors come from
// a threshold shadow model and are queued as beats are driven, then popped
// when the DUT presents a vector. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_logicnet_input_quantizer;

    localparam int NF = 32;
    localparam int FW = 16;
    localparam int BW = 2;
    localparam int NT = 3;
    localparam int DW = NF * BW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [FW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          thr_we = 1'b0;
    logic [4:0]    thr_feat = '0;
    logic [BW-1:0] thr_sel = '0;
    logic [FW-1:0] thr_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          err_frame;

    logic [DW-1:0] exp_q [$];
    logic [FW-1:0] thr_m [NF][NT];
    logic [FW-1:0] vec_in [NF];
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    logicnet_input_quantizer dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .thr_we    (thr_we),
        .thr_feat  (thr_feat),
        .thr_sel   (thr_sel),
        .thr_data  (thr_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .err_frame (err_frame)
    );

    function automatic logic [BW-1:0] model_code(input int f, input logic [FW-1:0] v);
        int c;
        c = 0;
        for (int k = 0; k < NT; k++) begin
            if (v >= thr_m[f][k]) c++;
        end
        return c[BW-1:0];
    endfunction

    task automatic clear_model();
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < NT; k++)
                thr_m[f][k] = '0;
    endtask

    task automatic thr_write(input int f, input int sel, input logic [FW-1:0] d);
        thr_we = 1'b1; thr_feat = f[4:0]; thr_sel = sel[BW-1:0]; thr_data = d;
        @(negedge clk);
        thr_we = 1'b0;
        if (sel < NT) thr_m[f][sel] = d;
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (s_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (s_ready !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL s_ready_timeout: s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic send_beat(input logic [FW-1:0] d, input logic l);
        wait_ready();
        s_valid = 1'b1; s_data = d; s_last = l;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_vector(input logic mark_last);
        logic [DW-1:0] e;
        e = '0;
        for (int i = 0; i < NF; i++) begin
            e[i*BW +: BW] = model_code(i, vec_in[i]);
            send_beat(vec_in[i], (i == NF-1) ? mark_last : 1'b0);
        end
        exp_q.push_back(e);
    endtask

    task automatic recv_vector(output logic ok, output logic [DW-1:0] d);
        int w;
        w = 0;
        while (m_valid !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        ok = (m_valid === 1'b1);
        d  = m_data;
        if (ok) begin
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
        end else begin
            n_tests++; n_fail++;
            $display("FAIL m_valid_timeout: m_valid=%b required 1", m_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({m_valid, m_data, err_frame, s_ready} !== {1'b0, {DW{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: m_valid=%b m_data=%h err=%b s_ready=%b required 0/0/0/0",
                     m_valid, m_data, err_frame, s_ready);
        end
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        n_tests++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic test_quantize();
        logic [FW-1:0] samples [4];
        logic [BW-1:0] codes [4];
        logic          ok;
        logic [DW-1:0] got, e;
        samples = '{16'd5, 16'd10, 16'd25, 16'd40};
        codes   = '{2'd0, 2'd1, 2'd2, 2'd3};
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < NT; k++)
                thr_write(f, k, 16'((k + 1) * 10));
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < NF; i++) vec_in[i] = '0;
            vec_in[0] = samples[v];
            send_vector(1'b1);
            n_tests++;
            if (m_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL quant_latency[%0d]: m_valid=%b required 1", v, m_valid);
            end
            recv_vector(ok, got);
            e = exp_q.pop_front();
            if (ok) begin
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL quant_vector[%0d]: got %h required %h", v, got, e);
                end
                n_tests++;
                if (got[1:0] !== codes[v]) begin
                    n_fail++;
                    $display("FAIL quant_code0[%0d]: got %0d required %0d", v, got[1:0], codes[v]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] e;
        int w;
        for (int i = 0; i < NF; i++) vec_in[i] = 16'($urandom_range(0, 45));
        send_vector(1'b1);
        e = exp_q.pop_front();
        w = 0;
        while (m_valid !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        n_tests++;
        if (m_data !== e || m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_vector: m_valid=%b m_data=%h required 1/%h", m_valid, m_data, e);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== e) begin
                n_fail++;
                $display("FAIL bp_stable[%0d]: m_valid=%b m_data=%h required 1/%h", c, m_valid, m_data, e);
            end
            n_tests++;
`ifdef LOGICNET_INQ_DOUBLE_BUFFER_EN
            if (s_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: s_ready=%b required 1", c, s_ready);
            end
`else
            if (s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: s_ready=%b required 0", c, s_ready);
            end
`endif
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        n_tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: m_valid=%b s_ready=%b required 0/1", m_valid, s_ready);
        end
    endtask

    task automatic test_framing();
        logic          ok;
        logic [DW-1:0] got, e;
        for (int i = 0; i < 4; i++) send_beat(16'd40, (i == 3));
        n_tests++;
        if (err_frame !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL early_last_pulse: err=%b m_valid=%b required 1/0", err_frame, m_valid);
        end
        @(negedge clk);
        n_tests++;
        if (err_frame !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL early_last_width: err=%b m_valid=%b required 0/0", err_frame, m_valid);
        end
        for (int i = 0; i < NF; i++) vec_in[i] = 16'((i * 7) % 45);
        send_vector(1'b1);
        recv_vector(ok, got);
        e = exp_q.pop_front();
        n_tests++;
        if (ok && got !== e) begin
            n_fail++;
            $display("FAIL early_last_repack: got %h required %h", got, e);
        end
        for (int i = 0; i < NF; i++) vec_in[i] = 16'((i * 13) % 41);
        send_vector(1'b0);
        n_tests++;
        if (err_frame !== 1'b1 || m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL missing_last: err=%b m_valid=%b required 1/1", err_frame, m_valid);
        end
        recv_vector(ok, got);
        e = exp_q.pop_front();
        n_tests++;
        if (ok && (got !== e || err_frame !== 1'b0)) begin
            n_fail++;
            $display("FAIL missing_last_vector: got %h err=%b required %h/0", got, err_frame, e);
        end
    endtask

    task automatic test_reset_mid();
        logic          ok;
        logic [DW-1:0] got;
        for (int i = 0; i < 10; i++) send_beat(16'd50, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({m_valid, m_data, s_ready, err_frame} !== {1'b0, {DW{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: m_valid=%b m_data=%h s_ready=%b err=%b required 0/0/0/0",
                     m_valid, m_data, s_ready, err_frame);
        end
        rst = 1'b0;
        clear_model();
        for (int i = 0; i < NF - 1; i++) send_beat(16'(i + 1), 1'b0);
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_idx: m_valid=%b required 0 before beat 32", m_valid);
        end
        send_beat(16'd32, 1'b1);
        recv_vector(ok, got);
        n_tests++;
        if (ok && got !== {DW{1'b1}}) begin
            n_fail++;
            $display("FAIL mid_reset_thr_cleared: got %h required all codes 3", got);
        end
    endtask

    task automatic test_thr_same_cycle();
        logic          ok;
        logic [DW-1:0] got, e;
        thr_write(5, 1, 16'd200);
        for (int i = 0; i < NF; i++) vec_in[i] = '0;
        vec_in[5] = 16'd150;
        e = '0;
        for (int i = 0; i < NF; i++) begin
            e[i*BW +: BW] = model_code(i, vec_in[i]);
            if (i == 5) begin
                wait_ready();
                s_valid = 1'b1; s_data = vec_in[i]; s_last = 1'b0;
                thr_we = 1'b1; thr_feat = 5'd5; thr_sel = 2'd1; thr_data = 16'd100;
                @(negedge clk);
                s_valid = 1'b0; thr_we = 1'b0;
                thr_m[5][1] = 16'd100;
            end else begin
                send_beat(vec_in[i], (i == NF-1));
            end
        end
        exp_q.push_back(e);
        recv_vector(ok, got);
        e = exp_q.pop_front();
        n_tests++;
        if (ok && (got !== e || got[11:10] !== 2'd2)) begin
            n_fail++;
            $display("FAIL thr_same_cycle_old: got %h (f5=%0d) required %h (f5=2)", got, got[11:10], e);
        end
        thr_write(5, 3, 16'hFFFF);
        send_vector(1'b1);
        recv_vector(ok, got);
        e = exp_q.pop_front();
        n_tests++;
        if (ok && (got !== e || got[11:10] !== 2'd3)) begin
            n_fail++;
            $display("FAIL thr_next_vector_new: got %h (f5=%0d) required %h (f5=3)", got, got[11:10], e);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_quantize();
        test_backpressure();
        test_framing();
        test_reset_mid();
        test_thr_same_cycle();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
